multiplier_sequencer: RTL and testbench

MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

---
 rtl/multiplier_sequencer.sv | 158 +++++++++++++++
 tb/tb_multiplier_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer: sequences an 8x8 signed shift-add multiply through an
// external 9-bit adder_sub. The product appears as {Aval, Bval}, with X holding
// its sign-extension bit.
// Optional build macro: MULT_SKIP_ADD_EN. When it is defined, the sequencer
// bypasses the ADD cycle for every multiplier bit that is 0.
module multiplier_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  input  logic [8:0] add_result,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_sub,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] a_q, a_next;
  logic [DATA_W-1:0] b_q, b_next;
  logic              x_q, x_next;
  logic              busy_next, done_next, add_sub_next;

  // State, datapath and registered status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      add_sub <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      a_q     <= a_next;
      b_q     <= b_next;
      x_q     <= x_next;
      busy    <= busy_next;
      done    <= done_next;
      add_sub <= add_sub_next;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    a_next     = a_q;
    b_next     = b_q;
    x_next     = x_q;

    unique case (state)
      IDLE: begin
        // A load request takes priority over a start request.
        if (ClearA_LoadB) begin
          a_next = '0;
          x_next = 1'b0;
          b_next = S;
        end else if (Run) begin
          state_next = START;
        end
      end

      START: begin
        // B is kept so that back-to-back multiplies chain on the low byte.
        a_next   = '0;
        x_next   = 1'b0;
        cnt_next = '0;
`ifdef MULT_SKIP_ADD_EN
        state_next = b_q[0] ? ADD : SHIFT;
`else
        state_next = ADD;
`endif
      end

      ADD: begin
        if (b_q[0]) begin
          x_next = add_result[8];
          a_next = add_result[7:0];
        end
        state_next = SHIFT;
      end

      SHIFT: begin
        a_next = {x_q, a_q[DATA_W-1:1]};
        b_next = {a_q[0], b_q[DATA_W-1:1]};
        if (cnt == LAST_BIT) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
`ifdef MULT_SKIP_ADD_EN
          // b_q[1] becomes B[0] once this shift completes.
          state_next = b_q[1] ? ADD : SHIFT;
`else
          state_next = ADD;
`endif
        end
      end

      DONE: begin
        // A new multiply starts only after Run has been released.
        if (!Run) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags come from the next state so they change together with the state register.
  always_comb begin
    busy_next    = 1'b0;
    done_next    = 1'b0;
    add_sub_next = 1'b0;
    if ((state_next == START) || (state_next == ADD) || (state_next == SHIFT)) begin
      busy_next = 1'b1;
    end
    if (state_next == DONE) begin
      done_next = 1'b1;
    end
    // The multiplier sign bit carries a negative weight, so that step subtracts.
    if ((state_next == ADD) && (cnt_next == LAST_BIT)) begin
      add_sub_next = 1'b1;
    end
  end

  // Adder operands and register views.
  assign add_a = a_q;
  assign add_b = S;
  assign Aval  = a_q;
  assign Bval  = b_q;
  assign X     = x_q;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench for multiplier_sequencer. It models the external 9-bit
// adder_sub and keeps a scoreboard of the products it expects.
module tb_multiplier_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [8:0] add_result;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_sub;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic [7:0] b_model;
  logic [8:0] ext_a;
  logic [8:0] ext_b;

  multiplier_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .add_result   (add_result),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sub      (add_sub),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .busy         (busy),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External 9-bit adder_sub: sign-extended a +/- b.
  always_comb begin
    ext_a      = {add_a[7], add_a};
    ext_b      = {add_b[7], add_b};
    add_result = add_sub ? (ext_a - ext_b) : (ext_a + ext_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load B from S through the IDLE load request.
  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    S            = v;
    ClearA_LoadB = 1'b1;
    @(posedge Clk);
    #1;
    check("load_B", 32'(Bval), 32'(v));
    check("load_A", 32'(Aval), 32'h0);
    check("load_X", 32'(X), 32'h0);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    b_model      = v;
  endtask

  // Run one multiply of b_model by s. Optionally hold Run in DONE and poke ClearA_LoadB mid-run.
  task automatic run_mult(input logic [7:0] s, input int hold, input bit poke);
    exp_t        e;
    exp_t        got_e;
    int          pa;
    int          pb;
    logic [15:0] p;
    int          n;
    pa    = $signed(b_model);
    pb    = $signed(s);
    p     = 16'(pa * pb);
    e.a   = p[15:8];
    e.b   = p[7:0];
    e.x   = p[15];
`ifdef MULT_SKIP_ADD_EN
    e.lat = 10 + $countones(b_model);
`else
    e.lat = 18;
`endif
    sb.push_back(e);
    @(negedge Clk);
    S   = s;
    Run = 1'b1;
    n   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (poke && i == 5) ClearA_LoadB = 1'b1;
      if (poke && i == 8) ClearA_LoadB = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
    ClearA_LoadB = 1'b0;
    if (n == 0) n = 41;
    got_e = sb.pop_front();
    check("latency", 32'(n), 32'(got_e.lat));
    check("prod_A", 32'(Aval), 32'(got_e.a));
    check("prod_B", 32'(Bval), 32'(got_e.b));
    check("prod_X", 32'(X), 32'(got_e.x));
    check("done_busy", 32'(busy), 32'h0);
    b_model = got_e.b;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      check("hold_done", 32'(done), 32'h1);
      check("hold_busy", 32'(busy), 32'h0);
      check("hold_A", 32'(Aval), 32'(got_e.a));
    end
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk);
    #1;
    check("idle_done", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    b_model      = 8'h00;
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_A", 32'(Aval), 32'h0);
    check("rst_B", 32'(Bval), 32'h0);
    check("rst_X", 32'(X), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_add_sub", 32'(add_sub), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    // Positive x positive, Run held in DONE for a while.
    load_b(8'h3B);
    run_mult(8'h07, 4, 1'b0);
    // Consecutive multiply reuses the low product byte (0x9D).
    run_mult(8'h02, 0, 1'b0);
    // Signed operands.
    load_b(8'h3B);
    run_mult(8'hF9, 0, 1'b0);
    load_b(8'hC5);
    run_mult(8'h07, 0, 1'b1);
    // -128 x -128 corner.
    load_b(8'h80);
    run_mult(8'h80, 0, 1'b0);
    // All-ones multiplier.
    load_b(8'hFF);
    run_mult(8'h05, 0, 1'b0);

    // Run and ClearA_LoadB together in IDLE: load only.
    @(negedge Clk);
    S            = 8'h11;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    @(posedge Clk);
    #1;
    check("both_B", 32'(Bval), 32'h11);
    check("both_busy", 32'(busy), 32'h0);
    @(negedge Clk);
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    b_model      = 8'h11;
    @(posedge Clk);
    #1;
    check("both_idle_busy", 32'(busy), 32'h0);

    // Random operands.
    for (int k = 0; k < 6; k++) begin
      load_b(8'($urandom));
      run_mult(8'($urandom), 0, 1'b0);
    end

    // Asynchronous reset in the middle of a multiply (SHIFT, cnt=3 in the default build).
    load_b(8'h5A);
    @(negedge Clk);
    S   = 8'h33;
    Run = 1'b1;
    repeat (9) @(posedge Clk);
    #1;
    check("mid_busy", 32'(busy), 32'h1);
    #1;
    Reset = 1'b1;
    #1;
    check("mid_rst_A", 32'(Aval), 32'h0);
    check("mid_rst_B", 32'(Bval), 32'h0);
    check("mid_rst_X", 32'(X), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_add_sub", 32'(add_sub), 32'h0);
    @(negedge Clk);
    Reset   = 1'b0;
    Run     = 1'b0;
    b_model = 8'h00;
    @(posedge Clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'h0);
    // Zero multiplier after reset.
    run_mult(8'h7F, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
